mem_loader: RTL and testbench

//   Fills the 16-entry x 4-bit sample memory that the max-finder datapath scans.

---
 rtl/mem_loader.sv | 145 ++++++++++++++
 tb/tb_mem_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader
//   Fills the sample memory scanned by the max-finder datapath. Samples arrive
//   on a valid/ready stream and are written to addresses 0..LASTADDR in order;
//   done is raised once the last address is written and acts as the
//   max-finder's go. The read port is combinational so the max-finder can
//   sample din in the same cycle it presents addr.
//
// Ports
//   clk_i       rising-edge clock
//   reset_i     asynchronous, active-high reset
//   start_i     begin/restart a load at address 0 (pulse or level)
//   in_valid_i  in_data_i holds a sample
//   in_data_i   sample to store
//   in_ready_o  a sample is accepted this cycle when in_valid_i is high
//   wr_addr_o   address the next accepted sample is written to
//   loading_o   high while loading
//   done_o      memory full; held until next start or reset
//   rd_addr_i   read address (max-finder addr)
//   rd_data_o   mem[rd_addr_i] (max-finder din)
module mem_loader #(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned LASTADDR = 15
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              loading_o,
  output logic              done_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned        DEPTH  = LASTADDR + 1;
  localparam logic [ADDR_W-1:0]  LAST_A = ADDR_W'(LASTADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                done_q, done_d;
  logic                xfer;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. start always wins: it rewinds to address 0 from any
  // state, and because in_ready is low during start no sample is lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    done_d    = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_LOAD;
          wr_addr_d = '0;
        end
      end
      S_LOAD: begin
        if (start_i) begin
          wr_addr_d = '0;
        end else if (xfer) begin
          // The LASTADDR compare terminates the load; the address never wraps
          // into a second write pass.
          if (wr_addr_q == LAST_A) begin
            state_d   = S_FULL;
            done_d    = 1'b1;
            wr_addr_d = '0;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end
      end
      S_FULL: begin
        if (start_i) begin
          state_d   = S_LOAD;
          done_d    = 1'b0;
          wr_addr_d = '0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        wr_addr_d = '0;
        done_d    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    loading_o  = (state_q == S_LOAD);
    in_ready_o = (state_q == S_LOAD) && !start_i;
    done_o     = done_q;
    wr_addr_o  = wr_addr_q;
  end

  assign xfer = in_valid_i && in_ready_o;

  // ---------------------------------------------------------------------------
  // Sample memory: one register per entry, cleared by reset so a fresh
  // max-finder scan after reset sees all zeros.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic we;
    assign we = xfer && (wr_addr_q == ADDR_W'(g));
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)  mem_q[g] <= '0;
      else if (we)  mem_q[g] <= in_data_i;
    end
  end

  // Asynchronous read, no write bypass: a same-cycle write to rd_addr shows
  // up only after the edge. Addresses beyond the memory read as zero.
  always_comb begin
    rd_data_o = '0;
    if (int'(rd_addr_i) < int'(DEPTH)) rd_data_o = mem_q[rd_addr_i];
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader. Inputs change 1ns after the rising
// edge; outputs are sampled there too, away from the edge. Accepted samples
// are pushed to a scoreboard queue as they are driven and popped on readback.
module tb_mem_loader;

  logic       clk, reset, start, in_valid;
  logic [3:0] in_data, rd_addr;
  logic       in_ready, loading, done;
  logic [3:0] wr_addr, rd_data;

  typedef struct { logic [3:0] addr; logic [3:0] data; } sb_t;
  sb_t        sb[$];
  logic [3:0] exp_mem [16];
  logic [3:0] exp_wa;
  int         checks, errors;

  mem_loader #(.DATA_W(4), .ADDR_W(4), .LASTADDR(15)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .in_valid_i(in_valid),
    .in_data_i(in_data), .in_ready_o(in_ready), .wr_addr_o(wr_addr),
    .loading_o(loading), .done_o(done), .rd_addr_i(rd_addr), .rd_data_o(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted beat and record the expected memory write.
  task automatic beat(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    sb.push_back('{addr: exp_wa, data: d});
    exp_mem[exp_wa] = d;
    exp_wa = exp_wa + 4'd1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start  = 1'b0;
    exp_wa = 4'd0;
  endtask

  task automatic drain(input string tag);
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.addr;
      #1;
      checks++;
      if (rd_data !== e.data) begin
        errors++;
        $display("FAIL %s rd[%0h]: got %0h expected %0h", tag, e.addr, rd_data, e.data);
      end
    end
    tick();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 4'd0;
    exp_wa = 4'd0;
    sb.delete();
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({in_ready, loading, done, wr_addr} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b ld=%b dn=%b wa=%0h expected all 0",
               in_ready, loading, done, wr_addr);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== 4'd0) begin
        errors++;
        $display("FAIL reset_mem[%0d]: got %0h expected 0", i, rd_data);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start_pulse();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i);
      #0;
      checks++;
      if (in_ready !== 1'b1 || wr_addr !== 4'(i) || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_beat%0d: got rdy=%b wa=%0h dn=%b expected 1 %0h 0",
                 i, in_ready, wr_addr, done, i);
      end
      beat(4'(i));
    end
    checks++;
    if (done !== 1'b1 || loading !== 1'b0 || in_ready !== 1'b0 || wr_addr !== 4'd0) begin
      errors++;
      $display("FAIL b2b_done: got dn=%b ld=%b rdy=%b wa=%0h expected 1 0 0 0",
               done, loading, in_ready, wr_addr);
    end
    rd_addr = 4'h5;
    #1;
    checks++;
    if (rd_data !== 4'h5) begin
      errors++;
      $display("FAIL b2b_rd5: got %0h expected 5", rd_data);
    end
    drain("b2b");
  endtask

  task automatic test_toggle();
    int edges, cnt;
    edges = 0;
    cnt   = 0;
    start_pulse();
    while (!done && edges < 64) begin
      checks++;
      if (wr_addr !== 4'(cnt)) begin
        errors++;
        $display("FAIL toggle_wa@%0d: got %0h expected %0h", edges, wr_addr, cnt);
      end
      if (edges % 2 == 0) begin
        beat(4'($urandom_range(0, 15)));
        cnt++;
      end else begin
        in_valid = 1'b0;
        in_data  = 4'($urandom_range(0, 15));
        tick();
      end
      edges++;
    end
    checks++;
    if (edges !== 31 || cnt !== 16) begin
      errors++;
      $display("FAIL toggle_len: got edges=%0d beats=%0d expected 31 16", edges, cnt);
    end
    drain("toggle");
  endtask

  task automatic test_restart();
    start_pulse();
    for (int i = 0; i < 16; i++) beat(4'hA);
    sb.delete();
    start_pulse();
    for (int i = 0; i < 7; i++) beat(4'h3);
    // Second start with a valid sample present: nothing may be accepted.
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'h5;
    #0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_rdy: got %b expected 0", in_ready);
    end
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    exp_wa   = 4'd0;
    checks++;
    if (wr_addr !== 4'd0 || done !== 1'b0 || loading !== 1'b1) begin
      errors++;
      $display("FAIL restart_state: got wa=%0h dn=%b ld=%b expected 0 0 1",
               wr_addr, done, loading);
    end
    for (int i = 7; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== 4'hA) begin
        errors++;
        $display("FAIL restart_keep[%0d]: got %0h expected a", i, rd_data);
      end
    end
    drain("restart");
  endtask

  task automatic test_same_addr();
    start_pulse();
    for (int i = 0; i < 16; i++) beat((i == 4) ? 4'h2 : 4'(i));
    sb.delete();
    start_pulse();
    for (int i = 0; i < 4; i++) beat(4'h1);
    rd_addr  = 4'h4;
    in_valid = 1'b1;
    in_data  = 4'h9;
    #0;
    checks++;
    if (rd_data !== 4'h2 || wr_addr !== 4'h4) begin
      errors++;
      $display("FAIL rw_old: got rd=%0h wa=%0h expected 2 4", rd_data, wr_addr);
    end
    beat(4'h9);
    checks++;
    if (rd_data !== 4'h9) begin
      errors++;
      $display("FAIL rw_new: got %0h expected 9", rd_data);
    end
    for (int i = 5; i < 16; i++) beat(4'(15 - i));
    drain("rw");
  endtask

  task automatic test_reset_midload();
    start_pulse();
    for (int i = 0; i < 9; i++) beat(4'(i + 3));
    in_valid = 1'b1;
    reset    = 1'b1;
    #1;
    checks++;
    if ({in_ready, loading, done, wr_addr} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b ld=%b dn=%b wa=%0h expected all 0",
               in_ready, loading, done, wr_addr);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== 4'd0) begin
        errors++;
        $display("FAIL async_reset_mem[%0d]: got %0h expected 0", i, rd_data);
      end
    end
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_mem[i] = 4'd0;
    sb.delete();
    tick();
  endtask

  task automatic test_ignore();
    // IDLE after reset
    in_valid = 1'b1;
    in_data  = 4'hE;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (wr_addr !== 4'd0 || loading !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_ignore: got wa=%0h ld=%b rdy=%b expected 0 0 0",
                 wr_addr, loading, in_ready);
      end
    end
    in_valid = 1'b0;
    // Load a known image, then hold valid data while FULL
    start_pulse();
    for (int i = 0; i < 16; i++) beat(4'((i * 7) & 15));
    sb.delete();
    in_valid = 1'b1;
    in_data  = 4'hE;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (done !== 1'b1 || wr_addr !== 4'd0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_ignore: got dn=%b wa=%0h rdy=%b expected 1 0 0",
                 done, wr_addr, in_ready);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== exp_mem[i]) begin
        errors++;
        $display("FAIL ignore_mem[%0d]: got %0h expected %0h", i, rd_data, exp_mem[i]);
      end
    end
    tick();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'd0;
    rd_addr  = 4'd0;
    exp_wa   = 4'd0;
    #2;
    test_reset();
    test_back_to_back();
    test_toggle();
    test_restart();
    test_same_addr();
    test_reset_midload();
    test_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule
